// File: rtl/uart_tx_buffered_if.sv
// Host-side handshake and serial line of the buffered UART transmitter.
interface uart_tx_buffered_if;
  localparam int unsigned DATA_W = 8;

  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  logic              tx_rdy;
  logic              busy;
  logic              tx_done;
  logic              TX;

  modport master (output trmt, output tx_data,
                  input  tx_rdy, input busy, input tx_done, input TX);
  modport slave  (input  trmt, input  tx_data,
                  output tx_rdy, output busy, output tx_done, output TX);
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter, LSB first, idle-high line, with a one-entry holding
// register so queued frames follow each other with no idle gap.
module uart_tx_buffered #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input logic                clk,
  input logic                rst,
  uart_tx_buffered_if.slave  bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                tx_q, tx_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic                busy_q, busy_d;
  logic                tx_done_q, tx_done_d;
  logic                accept;
  logic                bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      tx_rdy_q    <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      tx_rdy_q    <= tx_rdy_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Next-state, bit timing, shifter and holding-register control.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    tx_done_d   = 1'b0;

    accept  = bus.trmt && tx_rdy_q;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : CNT_W'(baud_q + 1'b1);
      if (accept) begin
        hold_d      = bus.tx_data;
        hold_full_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (accept) begin
          shift_d = bus.tx_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = BIT_W'(bit_q + 1'b1);
            tx_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_done_d = 1'b1;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
            tx_d        = 1'b0;
          end else if (accept) begin
            // Byte arriving on the last stop cycle bypasses the empty holding register.
            shift_d     = bus.tx_data;
            hold_full_d = 1'b0;
            state_d     = START;
            tx_d        = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_rdy_d = !hold_full_d;
    busy_d   = (state_d != IDLE);
  end

  assign bus.TX      = tx_q;
  assign bus.tx_rdy  = tx_rdy_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;

endmodule
